// File: rtl/median_stream_filter_if.sv
// Stream bundle for median_stream_filter: flush, input sample and result signals.
// MEDIAN_MINMAX_EN adds the out_min/out_max result lanes.
interface median_stream_filter_if #(
   parameter int unsigned WIDTH = 8
);
   logic             clr;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             win_full;
`ifdef MEDIAN_MINMAX_EN
   logic [WIDTH-1:0] out_min;
   logic [WIDTH-1:0] out_max;
`endif

   // Producer side: drives samples and flush, observes results.
   modport master (
      output clr,
      output in_valid,
      output in_data,
      input  out_valid,
      input  out_data,
`ifdef MEDIAN_MINMAX_EN
      input  out_min,
      input  out_max,
`endif
      input  win_full
   );

   // Filter side: consumes samples and flush, drives results.
   modport slave (
      input  clr,
      input  in_valid,
      input  in_data,
      output out_valid,
      output out_data,
`ifdef MEDIAN_MINMAX_EN
      output out_min,
      output out_max,
`endif
      output win_full
   );
endinterface

// File: rtl/median_stream_filter.sv
// Sliding-window median filter: one sample per cycle in, median of the last WIN
// accepted samples out two edges later. Rank-based selection breaks ties by
// window position, so duplicates always yield exactly one selected element.
// Optional feature macro: MEDIAN_MINMAX_EN (adds registered out_min/out_max).
module median_stream_filter #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned WIN    = 3,
   parameter int unsigned SIGNED = 0
) (
   input logic                   clk,
   input logic                   rst,
   median_stream_filter_if.slave bus
);
   localparam int unsigned CNT_W    = $clog2(WIN + 1);
   localparam int unsigned MED_RANK = (WIN - 1) / 2;

   if (WIN < 3 || WIN > 15 || (WIN % 2) == 0) begin : g_win_check
      $error("median_stream_filter: WIN must be odd and within 3..15");
   end

   logic [WIDTH-1:0] win_q [WIN];
   logic [WIDTH-1:0] win_d [WIN];
   logic [CNT_W-1:0] fill_q, fill_d;
   logic             v1_q, v1_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             win_full_q, win_full_d;
   logic [CNT_W-1:0] rank_c [WIN];
   logic [WIDTH-1:0] med_c;
`ifdef MEDIAN_MINMAX_EN
   logic [WIDTH-1:0] min_c, max_c;
   logic [WIDTH-1:0] out_min_q, out_min_d;
   logic [WIDTH-1:0] out_max_q, out_max_d;
`endif

   function automatic logic is_less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (SIGNED != 0) return $signed(a) < $signed(b);
      else             return a < b;
   endfunction

   // Rank of each window element; equal values are ordered by window index.
   always_comb begin
      for (int unsigned i = 0; i < WIN; i++) begin
         rank_c[i] = '0;
         for (int unsigned j = 0; j < WIN; j++) begin
            if (j != i) begin
               if (is_less(win_q[j], win_q[i]) || ((win_q[j] == win_q[i]) && (j < i))) begin
                  rank_c[i] = rank_c[i] + CNT_W'(1);
               end
            end
         end
      end
   end

   // Pick the elements holding the median (and extreme) ranks.
   always_comb begin
      med_c = '0;
`ifdef MEDIAN_MINMAX_EN
      min_c = '0;
      max_c = '0;
`endif
      for (int unsigned i = 0; i < WIN; i++) begin
         if (rank_c[i] == CNT_W'(MED_RANK)) med_c = win_q[i];
`ifdef MEDIAN_MINMAX_EN
         if (rank_c[i] == CNT_W'(0))       min_c = win_q[i];
         if (rank_c[i] == CNT_W'(WIN - 1)) max_c = win_q[i];
`endif
      end
   end

   // Next state: window shift, fill tracking, stage-1 flag, result capture, flush.
   always_comb begin
      win_d       = win_q;
      fill_d      = fill_q;
      v1_d        = 1'b0;
      out_valid_d = v1_q;
      out_data_d  = out_data_q;
`ifdef MEDIAN_MINMAX_EN
      out_min_d   = out_min_q;
      out_max_d   = out_max_q;
`endif

      if (v1_q) begin
         out_data_d = med_c;
`ifdef MEDIAN_MINMAX_EN
         out_min_d  = min_c;
         out_max_d  = max_c;
`endif
      end

      if (bus.in_valid) begin
         win_d[0] = bus.in_data;
         for (int unsigned k = 1; k < WIN; k++) begin
            win_d[k] = win_q[k-1];
         end
         if (fill_q != CNT_W'(WIN)) fill_d = fill_q + CNT_W'(1);
         v1_d = (fill_q >= CNT_W'(WIN - 1));
      end

      // Flush wins over a simultaneous sample and drops any stage-1 result.
      if (bus.clr) begin
         for (int unsigned k = 0; k < WIN; k++) begin
            win_d[k] = '0;
         end
         fill_d      = '0;
         v1_d        = 1'b0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
`ifdef MEDIAN_MINMAX_EN
         out_min_d   = '0;
         out_max_d   = '0;
`endif
      end

      win_full_d = (fill_d == CNT_W'(WIN));
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < WIN; k++) begin
            win_q[k] <= '0;
         end
         fill_q      <= '0;
         v1_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         win_full_q  <= 1'b0;
`ifdef MEDIAN_MINMAX_EN
         out_min_q   <= '0;
         out_max_q   <= '0;
`endif
      end else begin
         win_q       <= win_d;
         fill_q      <= fill_d;
         v1_q        <= v1_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         win_full_q  <= win_full_d;
`ifdef MEDIAN_MINMAX_EN
         out_min_q   <= out_min_d;
         out_max_q   <= out_max_d;
`endif
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.win_full  = win_full_q;
`ifdef MEDIAN_MINMAX_EN
   assign bus.out_min   = out_min_q;
   assign bus.out_max   = out_max_q;
`endif

endmodule

// File: tb/tb_median_stream_filter.sv
// Bench for median_stream_filter: three configurations (WIN=3 unsigned,
// WIN=5 signed, WIN=5 unsigned) share one stimulus stream and are compared
// every cycle against a sort-based reference, plus directed known answers.
// Optional feature macro: MEDIAN_MINMAX_EN (min/max lanes are then checked too).
module tb_median_stream_filter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   median_stream_filter_if #(.WIDTH(8)) if0 ();
   median_stream_filter_if #(.WIDTH(8)) if1 ();
   median_stream_filter_if #(.WIDTH(8)) if2 ();

   median_stream_filter #(.WIDTH(8), .WIN(3), .SIGNED(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   median_stream_filter #(.WIDTH(8), .WIN(5), .SIGNED(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   median_stream_filter #(.WIDTH(8), .WIN(5), .SIGNED(0)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state per configuration; hist[k][0] is the newest sample.
   int unsigned m_win [3];
   bit          m_sgn [3];
   logic [7:0]  hist  [3][15];
   int unsigned fill  [3];
   bit          p1v   [3];
   logic [7:0]  p1med [3];
   logic [7:0]  p1min [3];
   logic [7:0]  p1max [3];
   bit          e_ov  [3];
   logic [7:0]  e_od  [3];
   logic [7:0]  e_min [3];
   logic [7:0]  e_max [3];
   bit          e_full[3];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   // Sort the current window by value and report median, minimum and maximum.
   function automatic void window_stats(input int k, output logic [7:0] med,
                                        output logic [7:0] mn, output logic [7:0] mx);
      int         key [15];
      logic [7:0] val [15];
      int         n;
      n = int'(m_win[k]);
      for (int i = 0; i < n; i++) begin
         val[i] = hist[k][i];
         key[i] = m_sgn[k] ? int'($signed(hist[k][i])) : int'(hist[k][i]);
      end
      for (int i = 1; i < n; i++) begin
         for (int j = i; j > 0 && key[j-1] > key[j]; j--) begin
            int         tk;
            logic [7:0] tv;
            tk = key[j]; key[j] = key[j-1]; key[j-1] = tk;
            tv = val[j]; val[j] = val[j-1]; val[j-1] = tv;
         end
      end
      med = val[(n-1)/2];
      mn  = val[0];
      mx  = val[n-1];
   endfunction

   // Advance the reference by one rising edge.
   task automatic model_edge(input bit v, input logic [7:0] d, input bit c, input bit r);
      for (int k = 0; k < 3; k++) begin
         if (r || c) begin
            for (int i = 0; i < 15; i++) hist[k][i] = 8'h00;
            fill[k] = 0; p1v[k] = 1'b0; e_ov[k] = 1'b0; e_full[k] = 1'b0;
            e_od[k] = 8'h00; e_min[k] = 8'h00; e_max[k] = 8'h00;
         end else begin
            e_ov[k] = p1v[k];
            if (p1v[k]) begin
               e_od[k] = p1med[k]; e_min[k] = p1min[k]; e_max[k] = p1max[k];
            end
            p1v[k] = 1'b0;
            if (v) begin
               for (int i = 14; i > 0; i--) hist[k][i] = hist[k][i-1];
               hist[k][0] = d;
               if (fill[k] < m_win[k]) fill[k]++;
               p1v[k] = (fill[k] == m_win[k]);
               window_stats(k, p1med[k], p1min[k], p1max[k]);
            end
            e_full[k] = (fill[k] == m_win[k]);
         end
      end
   endtask

   task automatic check_all();
      check("w3u_valid", {7'b0, if0.out_valid}, {7'b0, e_ov[0]});
      check("w3u_data",  if0.out_data,          e_od[0]);
      check("w3u_full",  {7'b0, if0.win_full},  {7'b0, e_full[0]});
      check("w5s_valid", {7'b0, if1.out_valid}, {7'b0, e_ov[1]});
      check("w5s_data",  if1.out_data,          e_od[1]);
      check("w5s_full",  {7'b0, if1.win_full},  {7'b0, e_full[1]});
      check("w5u_valid", {7'b0, if2.out_valid}, {7'b0, e_ov[2]});
      check("w5u_data",  if2.out_data,          e_od[2]);
      check("w5u_full",  {7'b0, if2.win_full},  {7'b0, e_full[2]});
`ifdef MEDIAN_MINMAX_EN
      check("w3u_min", if0.out_min, e_min[0]);
      check("w3u_max", if0.out_max, e_max[0]);
      check("w5s_min", if1.out_min, e_min[1]);
      check("w5s_max", if1.out_max, e_max[1]);
      check("w5u_min", if2.out_min, e_min[2]);
      check("w5u_max", if2.out_max, e_max[2]);
`endif
   endtask

   // One clock cycle: drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input bit v, input logic [7:0] d, input bit c, input bit r);
      @(negedge clk);
      rst = r;
      if0.in_valid = v; if0.in_data = d; if0.clr = c;
      if1.in_valid = v; if1.in_data = d; if1.clr = c;
      if2.in_valid = v; if2.in_data = d; if2.clr = c;
      @(posedge clk);
      model_edge(v, d, c, r);
      #1;
      check_all();
   endtask

   task automatic feed(input logic [7:0] d);
      step(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic flush();
      step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before the directed sequence completed");
      $fatal(1, "watchdog");
   end

   initial begin
      m_win = '{3, 5, 5};
      m_sgn = '{1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 15; i++) hist[k][i] = 8'h00;
         fill[k] = 0; p1v[k] = 1'b0; p1med[k] = 8'h00; p1min[k] = 8'h00; p1max[k] = 8'h00;
         e_ov[k] = 1'b0; e_od[k] = 8'h00; e_min[k] = 8'h00; e_max[k] = 8'h00; e_full[k] = 1'b0;
      end
      if0.in_valid = 1'b0; if0.in_data = 8'h00; if0.clr = 1'b0;
      if1.in_valid = 1'b0; if1.in_data = 8'h00; if1.clr = 1'b0;
      if2.in_valid = 1'b0; if2.in_data = 8'h00; if2.clr = 1'b0;

      // Reset state
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("rst_valid", {7'b0, if0.out_valid}, 8'h00);
      check("rst_data",  if0.out_data,          8'h00);
      check("rst_full",  {7'b0, if0.win_full},  8'h00);

      // 4, 64, 8, 128 -> medians 8 then 64
      feed(8'd4);
      feed(8'd64);
      check("t1_nofill_valid", {7'b0, if0.out_valid}, 8'h00);
      feed(8'd8);
      check("t1_full", {7'b0, if0.win_full}, 8'h01);
      feed(8'd128);
      check("t1_r1_valid", {7'b0, if0.out_valid}, 8'h01);
      check("t1_r1_data",  if0.out_data, 8'd8);
`ifdef MEDIAN_MINMAX_EN
      check("t1_r1_min", if0.out_min, 8'd4);
      check("t1_r1_max", if0.out_max, 8'd64);
`endif
      idle();
      check("t1_r2_valid", {7'b0, if0.out_valid}, 8'h01);
      check("t1_r2_data",  if0.out_data, 8'd64);
      idle();
      check("t1_pulse_end", {7'b0, if0.out_valid}, 8'h00);
      check("t1_hold",      if0.out_data, 8'd64);

      // Duplicates: 16, 16, 2, 16, 2, 2 -> 16, 16, 2, 2
      flush();
      check("t2_clr_data", if0.out_data, 8'h00);
      feed(8'd16); feed(8'd16); feed(8'd2);
      feed(8'd16);
      check("t2_r1", if0.out_data, 8'd16);
      feed(8'd2);
      check("t2_r2", if0.out_data, 8'd16);
      feed(8'd2);
      check("t2_r3", if0.out_data, 8'd2);
      idle();
      check("t2_r4", if0.out_data, 8'd2);
      check("t2_r4_valid", {7'b0, if0.out_valid}, 8'h01);
      idle();
      check("t2_end_valid", {7'b0, if0.out_valid}, 8'h00);

      // WIN=5 signed vs unsigned on the same bit patterns
      flush();
      feed(8'hFD); feed(8'h64); feed(8'h80); feed(8'h07); feed(8'h00);
      feed(8'h7F);
      check("t3_s_r1", if1.out_data, 8'h00);
      check("t3_s_r1_valid", {7'b0, if1.out_valid}, 8'h01);
      check("t3_u_r1", if2.out_data, 8'h64);
      idle();
      check("t3_s_r2", if1.out_data, 8'h07);
      check("t3_u_r2", if2.out_data, 8'h64);

      // Flush together with the 3rd sample discards it
      flush();
      feed(8'd4); feed(8'd64);
      step(1'b1, 8'd8, 1'b1, 1'b0);
      check("t4_clr_full",  {7'b0, if0.win_full},  8'h00);
      idle();
      check("t4_clr_valid", {7'b0, if0.out_valid}, 8'h00);
      feed(8'd1); feed(8'd2); feed(8'd3);
      check("t4_early", {7'b0, if0.out_valid}, 8'h00);
      idle();
      check("t4_r_valid", {7'b0, if0.out_valid}, 8'h01);
      check("t4_r_data",  if0.out_data, 8'd2);
      idle();
      check("t4_single", {7'b0, if0.out_valid}, 8'h00);

      // Reset while a result sits in stage 1
      flush();
      feed(8'd1); feed(8'd2); feed(8'd3);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("t5_valid", {7'b0, if0.out_valid}, 8'h00);
      check("t5_data",  if0.out_data,          8'h00);
      check("t5_full",  {7'b0, if0.win_full},  8'h00);
      idle();
      check("t5_dropped", {7'b0, if0.out_valid}, 8'h00);
      feed(8'd5); feed(8'd6); feed(8'd7);
      idle();
      check("t5_refill", if0.out_data, 8'd6);

      // Sparse input with idle gaps
      flush();
      feed(8'd9); idle(); idle(); idle();
      feed(8'd1); idle(); idle(); idle();
      feed(8'd5);
      idle();
      check("t6_valid", {7'b0, if0.out_valid}, 8'h01);
      check("t6_data",  if0.out_data, 8'd5);
      idle(); idle(); idle();
      check("t6_hold_valid", {7'b0, if0.out_valid}, 8'h00);
      check("t6_hold_data",  if0.out_data, 8'd5);

      // Random traffic with occasional flush and reset
      for (int n = 0; n < 400; n++) begin
         bit         v;
         bit         c;
         bit         r;
         logic [7:0] d;
         v = ($urandom_range(0, 9) < 7);
         d = 8'($urandom);
         c = ($urandom_range(0, 49) == 0);
         r = ($urandom_range(0, 99) == 0);
         step(v, d, c, r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
